// File: rtl/add_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer: FSM states,
// operand width limits and the signed-overflow rule.
package add_ctrl_pkg;

   localparam int NBYTES_MIN = 2;
   localparam int NBYTES_MAX = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } add_state_t;

   // Signed overflow: both operands share a sign that the result does not.
   function automatic logic signed_overflow(input logic a_msb,
                                            input logic b_msb,
                                            input logic sum_msb);
      return (a_msb == b_msb) && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/eight_bit_adder_with_enable.sv
// 8-bit ripple-carry adder. Sum floats (high-Z) while enable is high;
// the carry-out is always driven.
module eight_bit_adder_with_enable (
   input  logic       enable,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin0,
   output logic [7:0] sum,
   output logic       cout8
);

   logic [8:0] carry;
   logic [7:0] sum_int;

   assign carry[0] = cin0;

   for (genvar gi = 0; gi < 8; gi++) begin : g_ripple
      assign sum_int[gi]   = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | ((a[gi] ^ b[gi]) & carry[gi]);
   end

   assign sum   = enable ? 8'bzzzz_zzzz : sum_int;
   assign cout8 = carry[8];

endmodule

// File: rtl/multi_byte_add_sequencer.sv
// Multi-byte add/subtract that walks the operands LSB byte first through a
// single shared 8-bit adder, then holds the result until it is consumed.
module multi_byte_add_sequencer
   import add_ctrl_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  StartValid,
   output logic                  StartReady,
   input  logic [8*NBYTES-1:0]   OpA,
   input  logic [8*NBYTES-1:0]   OpB,
   input  logic                  CinIn,
   input  logic                  SubMode,
   output logic                  ResValid,
   input  logic                  ResReady,
   output logic [8*NBYTES-1:0]   Result,
   output logic                  Cout,
   output logic                  Overflow,
   output logic                  Busy
);

   localparam int IDX_W = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   add_state_t state_reg, state_next;

   logic [8*NBYTES-1:0] a_reg, b_reg, result_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic                carry_reg, cout_reg, ovf_reg;
   logic                accept, adder_en;

   logic [7:0] a_bytes [NBYTES];
   logic [7:0] b_bytes [NBYTES];
   logic [7:0] a_byte, b_byte, byte_sum;
   logic       byte_cout;

   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign a_bytes[gi] = a_reg[8*gi +: 8];
      assign b_bytes[gi] = b_reg[8*gi +: 8];
   end

   assign a_byte = a_bytes[idx_reg];
   assign b_byte = b_bytes[idx_reg];

   eight_bit_adder_with_enable u_byte_adder (
      .enable (adder_en),
      .a      (a_byte),
      .b      (b_byte),
      .cin0   (carry_reg),
      .sum    (byte_sum),
      .cout8  (byte_cout)
   );

   always_ff @(posedge Clk) begin
      if (Reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      StartReady = 1'b0;
      ResValid   = 1'b0;
      Busy       = 1'b1;
      adder_en   = 1'b1;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            StartReady = 1'b1;
            Busy       = 1'b0;
            if (StartValid) begin
               accept     = 1'b1;
               state_next = ADD;
            end
         end
         ADD: begin
            adder_en = 1'b0;
            if (idx_reg == LAST_IDX) state_next = DONE;
         end
         DONE: begin
            ResValid = 1'b1;
            if (ResReady) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The adder sum is only sampled in ADD, where it is actively driven.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         idx_reg    <= '0;
         carry_reg  <= 1'b0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else if (accept) begin
         a_reg     <= OpA;
         b_reg     <= SubMode ? ~OpB : OpB;
         carry_reg <= SubMode ? 1'b1 : CinIn;
         idx_reg   <= '0;
      end else if (state_reg == ADD) begin
         result_reg[{idx_reg, 3'b000} +: 8] <= byte_sum;
         carry_reg <= byte_cout;
         idx_reg   <= idx_reg + IDX_W'(1);
         if (idx_reg == LAST_IDX) begin
            cout_reg <= byte_cout;
            ovf_reg  <= signed_overflow(a_byte[7], b_byte[7], byte_sum[7]);
         end
      end
   end

   assign Result   = result_reg;
   assign Cout     = cout_reg;
   assign Overflow = ovf_reg;

endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// Self-checking bench for multi_byte_add_sequencer (NBYTES=4): directed
// corner cases, DONE hold, mid-operation reset and randomized operations.
module tb_multi_byte_add_sequencer;

   localparam int NBYTES = 4;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        StartValid = 1'b0;
   logic        StartReady;
   logic [31:0] OpA = '0;
   logic [31:0] OpB = '0;
   logic        CinIn = 1'b0;
   logic        SubMode = 1'b0;
   logic        ResValid;
   logic        ResReady = 1'b0;
   logic [31:0] Result;
   logic        Cout;
   logic        Overflow;
   logic        Busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   multi_byte_add_sequencer #(.NBYTES(NBYTES)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .StartValid (StartValid),
      .StartReady (StartReady),
      .OpA        (OpA),
      .OpB        (OpB),
      .CinIn      (CinIn),
      .SubMode    (SubMode),
      .ResValid   (ResValid),
      .ResReady   (ResReady),
      .Result     (Result),
      .Cout       (Cout),
      .Overflow   (Overflow),
      .Busy       (Busy)
   );

   // Reference: exact integer arithmetic, then truncate / range-check.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub,
                                 output logic [31:0] r, output logic c,
                                 output logic o);
      longint ua, ub, sa, sb, exact_u, exact_s;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         exact_u = ua - ub;
         exact_s = sa - sb;
         c = (ua >= ub);
      end else begin
         exact_u = ua + ub + longint'(cin);
         exact_s = sa + sb + longint'(cin);
         c = (exact_u > 64'sd4294967295);
      end
      r = exact_u[31:0];
      o = (exact_s > 64'sd2147483647) || (exact_s < -64'sd2147483648);
   endfunction

   // Called at a negedge with the DUT idle.
   task automatic run_transaction(input string name, input logic [31:0] a,
                                  input logic [31:0] b, input logic cin,
                                  input logic sub, input int hold,
                                  input logic [31:0] exp_r, input logic exp_c,
                                  input logic exp_o);
      int cyc;
      n_checks++;
      if (StartReady !== 1'b1) begin
         n_fail++;
         $display("FAIL %s start_ready: got %b want 1", name, StartReady);
      end
      StartValid = 1'b1;
      OpA = a; OpB = b; CinIn = cin; SubMode = sub;
      @(posedge Clk);
      cyc = 0;
      do begin
         @(negedge Clk);
         cyc++;
         StartValid = 1'b0;
         OpA = $urandom; OpB = $urandom; CinIn = $urandom_range(0, 1);
         SubMode = $urandom_range(0, 1);
      end while (ResValid !== 1'b1 && cyc < 20);
      n_checks++;
      if (cyc != NBYTES + 1) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, NBYTES + 1);
      end
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) @(negedge Clk);
         n_checks++;
         if (Result !== exp_r || Cout !== exp_c || Overflow !== exp_o ||
             ResValid !== 1'b1 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s result: got r=%h c=%b o=%b v=%b busy=%b want r=%h c=%b o=%b v=1 busy=1",
                     name, Result, Cout, Overflow, ResValid, Busy, exp_r, exp_c, exp_o);
         end
      end
      ResReady = 1'b1;
      @(negedge Clk);
      ResReady = 1'b0;
      n_checks++;
      if (ResValid !== 1'b0 || StartReady !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s return_idle: got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
                  name, ResValid, StartReady, Busy);
      end
      $display("txn %s: a=%h b=%h cin=%b sub=%b -> r=%h c=%b o=%b (%0d cycles)",
               name, a, b, cin, sub, exp_r, exp_c, exp_o, cyc);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      StartValid = 1'b1;
      repeat (2) @(negedge Clk);
      n_checks++;
      if (StartReady !== 1'b1 || ResValid !== 1'b0 || Busy !== 1'b0 ||
          Result !== 32'h0 || Cout !== 1'b0 || Overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b v=%b busy=%b r=%h c=%b o=%b want 1 0 0 0 0 0",
                  StartReady, ResValid, Busy, Result, Cout, Overflow);
      end
      StartValid = 1'b0;
      Reset = 1'b0;
      @(negedge Clk);
      $display("txn reset: idle after reset with StartValid held");
   endtask

   task automatic test_directed();
      run_transaction("add_carry_chain", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0,
                      32'h0000_0100, 1'b0, 1'b0);
      run_transaction("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1,
                      32'h0000_0000, 1'b1, 1'b0);
      run_transaction("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0,
                      32'hFFFF_FFFE, 1'b0, 1'b0);
      run_transaction("add_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2,
                      32'h8000_0000, 1'b0, 1'b1);
      run_transaction("add_cin", 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 0,
                      32'h1234_5679, 1'b0, 1'b0);
   endtask

   task automatic test_hold_in_done();
      int cyc;
      StartValid = 1'b1; OpA = 32'h0000_1000; OpB = 32'h0000_0234;
      CinIn = 1'b0; SubMode = 1'b0;
      @(posedge Clk);
      cyc = 0;
      do begin
         @(negedge Clk);
         cyc++;
         StartValid = 1'b0;
      end while (ResValid !== 1'b1 && cyc < 20);
      for (int k = 0; k < 3; k++) begin
         StartValid = 1'b1; OpA = $urandom; OpB = $urandom; SubMode = 1'b1;
         @(negedge Clk);
         n_checks++;
         if (Result !== 32'h0000_1234 || StartReady !== 1'b0 || ResValid !== 1'b1 ||
             Cout !== 1'b0 || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_done[%0d]: got r=%h rdy=%b v=%b want r=00001234 rdy=0 v=1",
                     k, Result, StartReady, ResValid);
         end
      end
      StartValid = 1'b0;
      ResReady = 1'b1;
      @(negedge Clk);
      ResReady = 1'b0;
      @(negedge Clk);
      n_checks++;
      if (Busy !== 1'b0 || ResValid !== 1'b0 || Result !== 32'h0000_1234) begin
         n_fail++;
         $display("FAIL hold_ignored_req: got busy=%b v=%b r=%h want busy=0 v=0 r=00001234",
                  Busy, ResValid, Result);
      end
      $display("txn hold_in_done: result held 3 cycles, StartValid ignored");
   endtask

   task automatic test_reset_midop();
      logic [31:0] r;
      logic        c, o;
      StartValid = 1'b1; OpA = 32'hA5A5_A5A5; OpB = 32'h5A5A_5A5B;
      CinIn = 1'b0; SubMode = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      StartValid = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      n_checks++;
      if (StartReady !== 1'b1 || Busy !== 1'b0 || ResValid !== 1'b0 || Result !== 32'h0) begin
         n_fail++;
         $display("FAIL midop_reset: got rdy=%b busy=%b v=%b r=%h want 1 0 0 00000000",
                  StartReady, Busy, ResValid, Result);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge Clk);
         n_checks++;
         if (ResValid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_valid[%0d]: got v=%b want 0", k, ResValid);
         end
      end
      $display("txn reset_midop: operation abandoned at byte 2");
      model(32'h0F0F_F0F0, 32'h1111_2222, 1'b1, 1'b0, r, c, o);
      run_transaction("after_reset", 32'h0F0F_F0F0, 32'h1111_2222, 1'b1, 1'b0, 0, r, c, o);
   endtask

   task automatic test_random();
      logic [31:0] a, b, r;
      logic        cin, sub, c, o;
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         b = $urandom;
         if (n % 4 == 0) b = a;
         if (n % 5 == 1) a = {1'b0, a[30:0]} | 32'h7F00_0000;
         cin = $urandom_range(0, 1);
         sub = $urandom_range(0, 1);
         model(a, b, cin, sub, r, c, o);
         run_transaction($sformatf("rand%0d", n), a, b, cin, sub,
                         $urandom_range(0, 3), r, c, o);
      end
   endtask

   initial begin
      @(negedge Clk);
      test_reset();
      test_directed();
      test_hold_in_done();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
